spike_pattern_decoder: RTL and testbench
========================================

SPIKE_PATTERN_DECODER -- requirements
Module: spike_pattern_decoder

Interface
REQ-001 SHALL have parameter N, default 7, number of neuron spike inputs.
REQ-002 SHALL have parameter CNT_W, default 8, width of each per-neuron spike counter.
REQ-003 SHALL have parameter WINDOW, default 64, observation window length in clock cycles (legal range 1..65535).
REQ-004 SHALL have clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have reset  input  1  reset; one clock, reset is synchronous and active-high.
REQ-006 SHALL have spikes  input  N  raw neuron spike lines from the network.
REQ-007 SHALL have start  input  1  request to begin one observation window.
REQ-008 SHALL have thresh  input  CNT_W  per-neuron count threshold, sampled when start is accepted.
REQ-009 SHALL have busy  output  1  high in COUNT and DONE states.
REQ-010 SHALL have out_valid  output  1  result available.
REQ-011 SHALL have out_ready  input  1  consumer accepts result.
REQ-012 SHALL have pattern_out  output  4  recalled pattern, bit i for neuron i, i=0..3.
REQ-013 SHALL have winner  output  3  index of the neuron with the highest count; 7 = no spikes.

Function
REQ-014 SHALL implement states IDLE, COUNT, DONE.
REQ-015 IDLE: start=1 SHALL load thresh into a holding register, clear all counters and the window counter, and go to COUNT next cycle; start in COUNT or DONE SHALL be ignored.
REQ-016 COUNT: each cycle SHALL increment counter[k] when spikes[k]=1 and the registered spikes[k] from the previous cycle was 0 (rising edge only).
REQ-017 The previous-spike register SHALL update every cycle in every state, so edge detection is valid on the first COUNT cycle.
REQ-018 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-019 COUNT SHALL last exactly WINDOW cycles; if start is accepted at cycle t, edges in cycles t+1..t+WINDOW are counted, and out_valid SHALL rise at cycle t+WINDOW+1.
REQ-020 On leaving COUNT, pattern_out[i] SHALL be registered as (counter[i] >= held thresh), unsigned compare.
REQ-021 On leaving COUNT, winner SHALL be registered as the argmax over all N counters, with ties going to the lowest index, or 3'd7 if all counters are 0.
REQ-022 DONE: out_valid=1; pattern_out and winner SHALL hold stable until out_valid&&out_ready, then the block goes to IDLE next cycle.
REQ-023 out_ready=1 in the same cycle out_valid rises SHALL complete the handshake in that cycle.
REQ-024 A thresh of 0 SHALL yield pattern_out=4'b1111.
REQ-025 Changes on spikes outside COUNT SHALL not affect the counters.

Reset
REQ-026 Reset SHALL force IDLE and clear all counters, the window counter, the held thresh and the previous-spike register; it SHALL also drive busy=0, out_valid=0, pattern_out=0 and winner=3'd7.
REQ-027 Reset asserted mid-COUNT or in DONE SHALL discard the window; no out_valid SHALL follow.

Structure
REQ-028 A shared package SHALL hold the state encoding, the NO_WINNER constant (3'd7) and the defaults for N, CNT_W and WINDOW.
REQ-029 A sub-module spike_rate_counter SHALL provide the per-neuron edge detect and saturating counter, instantiated N times with clear and enable inputs.

Verification (N=7, CNT_W=8, WINDOW=16)
REQ-030 Drive thresh=3, start, then 4 edges on neuron 0, 2 on neuron 1 and none elsewhere -> out_valid at start+17, pattern_out=4'b0001, winner=0.
REQ-031 Drive equal counts of 5 on neurons 2 and 5 with thresh=5 -> pattern_out=4'b0100, winner=2.
REQ-032 Hold spikes high for the whole window, or drive no spikes -> counts ≤1 (a held level counts once) / winner=7, pattern_out=0.
REQ-033 Hold out_ready=0 for 10 cycles in DONE while pulsing start and toggling spikes -> outputs stable, start ignored; out_ready=1 -> IDLE next cycle.
REQ-034 Assert reset at window cycle 8 -> busy=0 next cycle, no out_valid, and a fresh start counts from zero.
REQ-035 Build with CNT_W=2 and drive 6 edges on neuron 3 -> count saturates at 3; thresh=3 gives pattern_out[3]=1.

Source files
------------

// File: rtl/spike_pattern_decoder_pkg.sv
`default_nettype none
// ============================================================================
// spike_pattern_decoder_pkg: shared state encoding, constants and defaults
// Rev 1.0 - initial release
// ============================================================================
package spike_pattern_decoder_pkg;

  localparam int DEF_N      = 7;
  localparam int DEF_CNT_W  = 8;
  localparam int DEF_WINDOW = 64;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [2:0] NO_WINNER = 3'd7;

endpackage : spike_pattern_decoder_pkg
`default_nettype wire

// File: rtl/spike_rate_counter.sv
`default_nettype none
// ============================================================================
// spike_rate_counter: rising-edge detect plus saturating per-neuron counter
// Rev 1.0 - initial release
// ============================================================================
module spike_rate_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_spike,
  input  logic             i_clear,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count_next
);

  logic             r_prev;
  logic [CNT_W-1:0] r_count;
  logic             w_rise;
  logic             w_sat;

  assign w_rise = i_spike & ~r_prev;
  assign w_sat  = &r_count;

  // The next value is exported so the parent can latch results on the same
  // edge that accounts for the final counting cycle.
  always_comb begin
    o_count_next = r_count;
    if (i_clear)
      o_count_next = '0;
    else if (i_en && w_rise && !w_sat)
      o_count_next = r_count + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev  <= 1'b0;
      r_count <= '0;
    end else begin
      r_prev  <= i_spike;
      r_count <= o_count_next;
    end
  end

endmodule : spike_rate_counter
`default_nettype wire

// File: rtl/spike_pattern_decoder.sv
`default_nettype none
// ============================================================================
// spike_pattern_decoder: counts spike edges over a window, reports pattern/winner
// Rev 1.0 - initial release
// ============================================================================
module spike_pattern_decoder
  import spike_pattern_decoder_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int WINDOW = DEF_WINDOW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     spikes,
  input  logic             start,
  input  logic [CNT_W-1:0] thresh,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       pattern_out,
  output logic [2:0]       winner
);

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [15:0]      r_win;
  logic [CNT_W-1:0] r_thresh;
  logic [3:0]       r_pattern;
  logic [2:0]       r_winner;

  logic             w_accept;
  logic             w_count_en;
  logic             w_last;
  logic [CNT_W-1:0] w_cnt_next [N];
  logic [3:0]       w_pattern;
  logic [2:0]       w_winner;
  logic [CNT_W-1:0] w_best;

  assign w_accept   = (r_state == ST_IDLE) && start;
  assign w_count_en = (r_state == ST_COUNT);
  assign w_last     = w_count_en && (r_win == 16'(WINDOW - 1));

  generate
    for (genvar k = 0; k < N; k++) begin : g_cnt
      spike_rate_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk          (clk),
        .rst          (reset),
        .i_spike      (spikes[k]),
        .i_clear      (w_accept),
        .i_en         (w_count_en),
        .o_count_next (w_cnt_next[k])
      );
    end
  endgenerate

  generate
    for (genvar i = 0; i < 4; i++) begin : g_pat
      if (i < N) begin : g_used
        assign w_pattern[i] = (w_cnt_next[i] >= r_thresh);
      end else begin : g_unused
        assign w_pattern[i] = 1'b0;
      end
    end
  endgenerate

  // Strict greater-than keeps ties on the lowest index; all-zero leaves NO_WINNER.
  always_comb begin
    w_best   = '0;
    w_winner = NO_WINNER;
    for (int k = 0; k < N; k++) begin
      if (w_cnt_next[k] > w_best) begin
        w_best   = w_cnt_next[k];
        w_winner = 3'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (start)     w_next_state = ST_COUNT;
      ST_COUNT: if (w_last)    w_next_state = ST_DONE;
      ST_DONE:  if (out_ready) w_next_state = ST_IDLE;
      default:                 w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state == ST_COUNT) || (r_state == ST_DONE);
    out_valid = (r_state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_win     <= '0;
      r_thresh  <= '0;
      r_pattern <= '0;
      r_winner  <= NO_WINNER;
    end else begin
      if (w_accept) begin
        r_win    <= '0;
        r_thresh <= thresh;
      end else if (w_count_en) begin
        r_win    <= r_win + 16'd1;
      end
      if (w_last) begin
        r_pattern <= w_pattern;
        r_winner  <= w_winner;
      end
    end
  end

  assign pattern_out = r_pattern;
  assign winner      = r_winner;

endmodule : spike_pattern_decoder
`default_nettype wire

// File: tb/tb_spike_pattern_decoder.sv
`default_nettype none
// ============================================================================
// tb_spike_pattern_decoder: scoreboard bench for the spike pattern decoder
// Rev 1.0 - initial release
// ============================================================================
module tb_spike_pattern_decoder;

  localparam int WIN = 16;

  typedef struct packed {
    logic [3:0] pat;
    logic [2:0] win;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, start, out_ready, dsel;
  logic [6:0] spikes;
  logic [7:0] thresh;
  logic [6:0] wv [WIN];
  exp_t       sb [$];
  int         n_checks = 0;
  int         n_fail   = 0;

  logic       busy1, valid1, busy2, valid2;
  logic [3:0] pat1, pat2;
  logic [2:0] win1, win2;
  logic       o_busy, o_valid;
  logic [3:0] o_pat;
  logic [2:0] o_win;

  always #5 clk = ~clk;

  spike_pattern_decoder #(.N(7), .CNT_W(8), .WINDOW(WIN)) u_dut (
    .clk(clk), .reset(reset), .spikes(spikes), .start(start & ~dsel),
    .thresh(thresh), .busy(busy1), .out_valid(valid1), .out_ready(out_ready),
    .pattern_out(pat1), .winner(win1)
  );

  spike_pattern_decoder #(.N(7), .CNT_W(2), .WINDOW(WIN)) u_dut_sat (
    .clk(clk), .reset(reset), .spikes(spikes), .start(start & dsel),
    .thresh(thresh[1:0]), .busy(busy2), .out_valid(valid2), .out_ready(out_ready),
    .pattern_out(pat2), .winner(win2)
  );

  assign o_busy  = dsel ? busy2  : busy1;
  assign o_valid = dsel ? valid2 : valid1;
  assign o_pat   = dsel ? pat2   : pat1;
  assign o_win   = dsel ? win2   : win1;

  // Behavioural reference: rising edges over the window, saturating at maxc.
  function automatic exp_t model(input int th, input logic [6:0] pre, input int maxc);
    int         cnt [7];
    int         best;
    logic [6:0] prev;
    exp_t       e;
    prev = pre;
    for (int k = 0; k < 7; k++) cnt[k] = 0;
    for (int c = 0; c < WIN; c++) begin
      for (int k = 0; k < 7; k++)
        if (wv[c][k] && !prev[k] && cnt[k] < maxc) cnt[k]++;
      prev = wv[c];
    end
    for (int i = 0; i < 4; i++) e.pat[i] = (cnt[i] >= th);
    best  = 0;
    e.win = 3'd7;
    for (int k = 0; k < 7; k++)
      if (cnt[k] > best) begin
        best  = cnt[k];
        e.win = 3'(k);
      end
    return e;
  endfunction

  function automatic void clear_wv();
    for (int c = 0; c < WIN; c++) wv[c] = '0;
  endfunction

  // Entered and left at a negedge; hold > 0 keeps out_ready low in DONE.
  task automatic run_window(input string name, input int th, input logic [6:0] pre,
                            input int hold);
    exp_t e;
    exp_t got;
    int   maxc;
    logic stable_bad;
    maxc = dsel ? 3 : 255;
    sb.push_back(model(dsel ? (th % 4) : th, pre, maxc));
    thresh = 8'(th);
    spikes = pre;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (o_busy !== 1'b1 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy_after_start: busy=%b valid=%b, required busy=1 valid=0", name, o_busy, o_valid);
    end
    for (int c = 0; c < WIN; c++) begin
      spikes = wv[c];
      if (o_valid !== 1'b0) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s early_valid: out_valid=1 at window cycle %0d, required 0", name, c);
      end
      @(negedge clk);
    end
    spikes = '0;
    n_checks++;
    if (o_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s latency: out_valid=%b %0d cycles after accept, required 1", name, o_valid, WIN);
    end
    if (hold > 0 && sb.size() > 0) begin
      e = sb[0];
      stable_bad = 1'b0;
      for (int h = 0; h < hold; h++) begin
        start  = ~start;
        spikes = 7'(h * 37);
        @(negedge clk);
        if (o_valid !== 1'b1 || o_pat !== e.pat || o_win !== e.win) stable_bad = 1'b1;
      end
      start  = 1'b0;
      spikes = '0;
      n_checks++;
      if (stable_bad) begin
        n_fail++;
        $display("FAIL %s done_hold: valid=%b pat=%b win=%0d, required 1/%b/%0d stable", name, o_valid, o_pat, o_win, e.pat, e.win);
      end
    end
    out_ready = 1'b1;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s scoreboard_empty: output with no expected entry", name);
    end else begin
      e   = sb.pop_front();
      got = '{pat: o_pat, win: o_win};
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s result: pattern_out=%b winner=%0d, required pattern_out=%b winner=%0d", name, o_pat, o_win, e.pat, e.win);
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s back_to_idle: valid=%b busy=%b, required 0/0", name, o_valid, o_busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; out_ready = 1'b0; dsel = 1'b0;
    spikes = '0; thresh = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (busy1 !== 1'b0 || valid1 !== 1'b0 || pat1 !== 4'b0000 || win1 !== 3'd7) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b valid=%b pat=%b win=%0d, required 0/0/0000/7", busy1, valid1, pat1, win1);
    end
  endtask

  task automatic test_basic();
    clear_wv();
    for (int c = 0; c < 8; c += 2) wv[c][0] = 1'b1;
    for (int c = 0; c < 4; c += 2) wv[c][1] = 1'b1;
    run_window("basic", 3, 7'h00, 0);
  endtask

  task automatic test_tie();
    clear_wv();
    for (int c = 0; c < 10; c += 2) begin
      wv[c][2] = 1'b1;
      wv[c][5] = 1'b1;
    end
    run_window("tie", 5, 7'h00, 0);
  endtask

  task automatic test_levels();
    for (int c = 0; c < WIN; c++) wv[c] = 7'h7F;
    run_window("held_from_low", 1, 7'h00, 0);
    run_window("held_from_high", 0, 7'h7F, 0);
    clear_wv();
    run_window("no_spikes", 2, 7'h00, 0);
  endtask

  task automatic test_done_hold();
    clear_wv();
    for (int c = 1; c < 12; c += 2) wv[c][6] = 1'b1;
    for (int c = 3; c < 8; c += 2) wv[c][3] = 1'b1;
    run_window("done_hold", 3, 7'h00, 10);
  endtask

  task automatic test_back_to_back();
    clear_wv();
    for (int c = 0; c < WIN; c += 3) wv[c] = 7'h15;
    run_window("b2b_a", 4, 7'h00, 0);
    for (int c = 0; c < WIN; c++) wv[c] = (c % 2 == 0) ? 7'h0A : 7'h00;
    run_window("b2b_b", 9, 7'h00, 0);
  endtask

  task automatic test_reset_mid();
    logic seen;
    thresh = 8'd1;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      spikes = (c % 2 == 0) ? 7'h10 : 7'h00;
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (busy1 !== 1'b0 || winner_is_reset() !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_busy: busy=%b win=%0d pat=%b, required busy=0 win=7 pat=0000", busy1, win1, pat1);
    end
    seen = 1'b0;
    for (int c = 0; c < 2 * WIN; c++) begin
      spikes = 7'(c);
      @(negedge clk);
      if (valid1 !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL reset_mid_no_valid: out_valid=1 after aborted window, required 0");
    end
    clear_wv();
    wv[2][6] = 1'b1;
    wv[5][6] = 1'b1;
    run_window("after_reset", 1, 7'h00, 0);
  endtask

  function automatic logic winner_is_reset();
    return (win1 === 3'd7) && (pat1 === 4'b0000);
  endfunction

  task automatic test_saturate();
    dsel = 1'b1;
    clear_wv();
    for (int c = 0; c < 12; c += 2) wv[c][3] = 1'b1;
    wv[1][0] = 1'b1;
    run_window("saturate", 3, 7'h00, 0);
    dsel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_levels();
    test_done_hold();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_spike_pattern_decoder
`default_nettype wire
